ibex_trace_buffer: RTL and testbench
====================================

Name: ibex_trace_buffer

Overview:
- Consumes the RVFI retirement stream produced by ibex_top, alongside or instead of the simulation tracer.
- Captures one compact record per retired instruction into a FIFO.
- Serialises each record into four 32-bit beats on a valid/ready trace port, so an off-core sink or debug streamer can log execution in silicon.
- Records that arrive while the FIFO is full are dropped and counted. The count is reported in the header of the next accepted record.

Parameters:
FifoDepth, 8, number of record entries; power of two, minimum 2.
DropCntWidth, 16, width of the saturating drop counter; maximum 16.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
trace_en_i  input  1  capture enable; when low, RVFI is ignored and nothing is counted
rvfi_valid  input  1  retirement strobe
rvfi_trap  input  1  instruction trapped
rvfi_halt  input  1  halt
rvfi_intr  input  1  first instruction of a trap handler
rvfi_mode  input  2  privilege mode
rvfi_rd_addr  input  5  destination register
rvfi_rd_wdata  input  32  destination write data
rvfi_pc_rdata  input  32  PC of the retired instruction
rvfi_insn  input  32  instruction word
trace_valid_o  output  1  beat valid
trace_ready_i  input  1  sink ready
trace_data_o  output  32  beat data
trace_last_o  output  1  final beat of a record
trace_drops_o  output  DropCntWidth  drops pending report
trace_level_o  output  $clog2(FifoDepth)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, active-low; also valid mid-transfer): all outputs are 0, FIFO empty, beat counter 0, drop counter 0. A partially sent record is abandoned and never resumed.
- Push: on a cycle with rvfi_valid && trace_en_i && !full, the record is written.
  - "full" is the occupancy at the start of the cycle. A same-cycle final-beat pop does NOT free a slot for that push.
  - The record holds {trap, halt, intr, mode, rd_addr, drop_cnt, pc, insn, rd_wdata}.
  - drop_cnt is the current counter value; the counter clears to 0 in the same cycle.
- Drop: on a cycle with rvfi_valid && trace_en_i && full, the record is discarded and the counter increments, saturating at all-ones. Push and drop are mutually exclusive.
- Serialisation: the head entry is emitted as beats 0..3, tracked by a 2-bit beat counter.
  - Beat 0, header:
    - [31:28] = 4'hA sync
    - [27] trap, [26] halt, [25] intr
    - [24:23] mode
    - [22:18] rd_addr
    - [17] ovf (drop_cnt != 0)
    - [16] = 0
    - [15:0] drop_cnt, zero-extended
  - Beat 1 = pc, beat 2 = insn, beat 3 = rd_wdata.
  - trace_last_o = 1 only on beat 3.
- Handshake: a beat transfers when valid && ready.
  - Once trace_valid_o is asserted, trace_data_o and trace_last_o stay stable until the transfer completes.
  - valid never drops without a transfer, except on reset.
  - The beat counter wraps 3->0 on a beat-3 transfer, and the entry pops in that same cycle.
- Latency:
  - A record pushed in cycle N into an empty FIFO gives trace_valid_o = 1 with beat 0 in cycle N+1.
  - With trace_ready_i held high, back-to-back records stream with no bubble: 4 cycles per record.
- trace_en_i falling: capture stops immediately. FIFO contents drain normally, and the drop counter holds its value.
- trace_level_o: registered occupancy, range 0..FifoDepth. Simultaneous push and pop leave it unchanged.

Decomposition:
- ibex_pkg gains:
  - trace_rec_t packed struct (the record fields above)
  - TraceSyncNibble = 4'hA
  - TraceBeatsPerRec = 4
- One sub-module, ibex_trace_fifo: a single-clock, registered-output FIFO of trace_rec_t with push/pop/full/empty/level.
  - It has no drop logic.
  - The top level holds the drop counter, beat counter and header packing.

Test Plan:
1. Reset, enable, single retire (pc=0x100, insn=0x00500093, rd=1, rd_wdata=5, mode=3), ready high -> cycles N+1..N+4 emit 0xA1840000, 0x00000100, 0x00500093, 0x00000005; last only on the 4th beat.
2. Ready low, 10 consecutive retires, FifoDepth=8 -> level reaches 8, trace_drops_o=2. Release ready, then one more retire -> its header has ovf=1 and drop_cnt=2, and the counter returns to 0.
3. Ready toggling 1-0-1-0 during a record -> data stable while stalled; all 4 beats delivered exactly once, in order.
4. Full FIFO, final-beat pop coincides with rvfi_valid -> record dropped (counter +1), level becomes 7.
5. trace_en_i=0 with 3 retires -> level stays 0, drops stay 0. Then assert rst_ni=0 mid-beat 2 of a draining record -> all outputs 0 immediately, and after release the FIFO is empty.
6. Force 0x10005 drops (DropCntWidth=16) -> trace_drops_o saturates at 0xFFFF; the next record header has [15:0]=0xFFFF and ovf=1.

Source files
------------

// File: rtl/ibex_trace_buffer_pkg.sv
// Shared types and constants for the RVFI trace buffer.
//   trace_rec_t      : one captured retirement record (FIFO entry)
//   TraceSyncNibble  : sync pattern placed in the top nibble of every header beat
//   TraceBeatsPerRec : number of 32-bit beats a record is serialised into
//   trace_header()   : packs the header beat of a record
package ibex_trace_buffer_pkg;

  localparam logic [3:0]  TraceSyncNibble  = 4'hA;
  localparam int unsigned TraceBeatsPerRec = 4;
  // Header carries a fixed 16-bit drop field; narrower counters are zero-extended.
  localparam int unsigned TraceDropFieldW  = 16;

  typedef struct packed {
    logic                       trap;
    logic                       halt;
    logic                       intr;
    logic [1:0]                 mode;
    logic [4:0]                 rd_addr;
    logic [TraceDropFieldW-1:0] drop_cnt;
    logic [31:0]                pc;
    logic [31:0]                insn;
    logic [31:0]                rd_wdata;
  } trace_rec_t;

  // {sync, trap, halt, intr, mode, rd_addr, ovf, 0, drop_cnt}
  function automatic logic [31:0] trace_header(input trace_rec_t rec);
    return {TraceSyncNibble, rec.trap, rec.halt, rec.intr, rec.mode, rec.rd_addr,
            (rec.drop_cnt != '0), 1'b0, rec.drop_cnt};
  endfunction

endpackage

// File: rtl/ibex_trace_fifo.sv
// Single-clock FIFO of trace records. Read data comes straight from the storage
// registers at the read pointer, so the head entry is stable until it is popped.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write request and record (ignored when full)
//   pop_i         : remove head entry (ignored when empty)
//   rdata_o       : head entry
//   full_o/empty_o: occupancy flags
//   level_o       : registered occupancy, 0..Depth
module ibex_trace_fifo
  import ibex_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth = 8  // power of two, >= 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  trace_rec_t             wdata_i,
  input  logic                   pop_i,
  output trace_rec_t             rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  trace_rec_t            mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: an entry is only observed after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ibex_trace_buffer.sv
// Captures one compact record per RVFI retirement into a FIFO and serialises
// each record as four 32-bit beats (header, pc, insn, rd_wdata) on a
// valid/ready trace port. Retirements seen while the FIFO is full are dropped
// and counted; the count rides in the header of the next accepted record.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   trace_en_i             : capture enable
//   rvfi_*                 : retirement stream from the core
//   trace_valid_o/ready_i  : beat handshake
//   trace_data_o/last_o    : beat payload, final-beat marker
//   trace_drops_o          : drops not yet reported in a header
//   trace_level_o          : FIFO occupancy
module ibex_trace_buffer
  import ibex_trace_buffer_pkg::*;
#(
  parameter int unsigned FifoDepth    = 8,   // power of two, >= 2
  parameter int unsigned DropCntWidth = 16   // <= 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       trace_en_i,
  input  logic                       rvfi_valid,
  input  logic                       rvfi_trap,
  input  logic                       rvfi_halt,
  input  logic                       rvfi_intr,
  input  logic [1:0]                 rvfi_mode,
  input  logic [4:0]                 rvfi_rd_addr,
  input  logic [31:0]                rvfi_rd_wdata,
  input  logic [31:0]                rvfi_pc_rdata,
  input  logic [31:0]                rvfi_insn,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_data_o,
  output logic                       trace_last_o,
  output logic [DropCntWidth-1:0]    trace_drops_o,
  output logic [$clog2(FifoDepth):0] trace_level_o
);

  localparam logic [1:0] LastBeat = 2'(TraceBeatsPerRec - 1);

  trace_rec_t              wr_rec, head_rec;
  logic                    fifo_full, fifo_empty;
  logic                    capture, push, drop, xfer, pop;
  logic [1:0]              beat_q, beat_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;

  // Full is the registered occupancy, so a same-cycle final-beat pop never
  // makes room for this cycle's retirement.
  assign capture = rvfi_valid && trace_en_i;
  assign push    = capture && !fifo_full;
  assign drop    = capture && fifo_full;

  always_comb begin
    wr_rec          = '0;
    wr_rec.trap     = rvfi_trap;
    wr_rec.halt     = rvfi_halt;
    wr_rec.intr     = rvfi_intr;
    wr_rec.mode     = rvfi_mode;
    wr_rec.rd_addr  = rvfi_rd_addr;
    wr_rec.drop_cnt[DropCntWidth-1:0] = drop_cnt_q;
    wr_rec.pc       = rvfi_pc_rdata;
    wr_rec.insn     = rvfi_insn;
    wr_rec.rd_wdata = rvfi_rd_wdata;
  end

  ibex_trace_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (wr_rec),
    .pop_i   (pop),
    .rdata_o (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (trace_level_o)
  );

  assign trace_valid_o = !fifo_empty;
  assign xfer          = trace_valid_o && trace_ready_i;
  assign pop           = xfer && (beat_q == LastBeat);
  assign trace_last_o  = trace_valid_o && (beat_q == LastBeat);
  assign trace_drops_o = drop_cnt_q;

  // Data is gated by valid so the port reads zero while idle or in reset.
  always_comb begin
    trace_data_o = '0;
    if (trace_valid_o) begin
      case (beat_q)
        2'd0:    trace_data_o = trace_header(head_rec);
        2'd1:    trace_data_o = head_rec.pc;
        2'd2:    trace_data_o = head_rec.insn;
        default: trace_data_o = head_rec.rd_wdata;
      endcase
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (xfer) beat_d = beat_q + 1'b1;  // 3 -> 0 wrap coincides with the pop
  end

  // Reporting the count in an accepted header clears it; drops saturate.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != {DropCntWidth{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      beat_q     <= beat_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_ibex_trace_buffer.sv
module tb_ibex_trace_buffer;

  localparam int unsigned FifoDepth    = 8;
  localparam int unsigned DropCntWidth = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        trace_en_i = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic        rvfi_trap = 1'b0;
  logic        rvfi_halt = 1'b0;
  logic        rvfi_intr = 1'b0;
  logic [1:0]  rvfi_mode = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_insn = '0;
  logic        trace_ready_i = 1'b0;
  logic        trace_valid_o;
  logic [31:0] trace_data_o;
  logic        trace_last_o;
  logic [DropCntWidth-1:0] trace_drops_o;
  logic [$clog2(FifoDepth):0] trace_level_o;

  always #5 clk_i = ~clk_i;

  ibex_trace_buffer #(
    .FifoDepth    (FifoDepth),
    .DropCntWidth (DropCntWidth)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .trace_en_i    (trace_en_i),
    .rvfi_valid    (rvfi_valid),
    .rvfi_trap     (rvfi_trap),
    .rvfi_halt     (rvfi_halt),
    .rvfi_intr     (rvfi_intr),
    .rvfi_mode     (rvfi_mode),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_insn     (rvfi_insn),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .trace_data_o  (trace_data_o),
    .trace_last_o  (trace_last_o),
    .trace_drops_o (trace_drops_o),
    .trace_level_o (trace_level_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: scoreboard of expected beats plus occupancy/drop state.
  // Evaluated on the falling edge, where inputs and outputs are settled.
  logic [31:0] sb [$];
  int          mlevel = 0;
  logic [1:0]  mbeat  = '0;
  logic [15:0] mdrops = '0;

  always @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb.delete();
      mlevel = 0;
      mbeat  = '0;
      mdrops = '0;
    end else begin
      logic mvalid, mpop;
      mvalid = (mlevel != 0);
      check("valid", 32'(trace_valid_o), 32'(mvalid));
      check("level", 32'(trace_level_o), 32'(mlevel));
      check("drops", 32'(trace_drops_o), 32'(mdrops));
      if (mvalid) begin
        check("data", trace_data_o, sb[mbeat]);
        check("last", 32'(trace_last_o), (mbeat == 2'd3) ? 32'd1 : 32'd0);
      end
      mpop = mvalid && trace_ready_i && (mbeat == 2'd3);
      if (mvalid && trace_ready_i) mbeat = mbeat + 2'd1;
      if (rvfi_valid && trace_en_i) begin
        if (mlevel == FifoDepth) begin
          if (mdrops != 16'hFFFF) mdrops = mdrops + 16'd1;
        end else begin
          sb.push_back({4'hA, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_rd_addr,
                        (mdrops != 16'd0), 1'b0, mdrops});
          sb.push_back(rvfi_pc_rdata);
          sb.push_back(rvfi_insn);
          sb.push_back(rvfi_rd_wdata);
          mdrops = '0;
          mlevel++;
        end
      end
      if (mpop) begin
        repeat (4) void'(sb.pop_front());
        mlevel--;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_rand_fields();
    {rvfi_trap, rvfi_halt, rvfi_intr} = 3'($urandom);
    rvfi_mode     = 2'($urandom);
    rvfi_rd_addr  = 5'($urandom);
    rvfi_rd_wdata = $urandom;
    rvfi_pc_rdata = $urandom;
    rvfi_insn     = $urandom;
  endtask

  task automatic retire_rand();
    set_rand_fields();
    rvfi_valid = 1'b1;
    cycles(1);
    rvfi_valid = 1'b0;
  endtask

  task automatic drain();
    trace_ready_i = 1'b1;
    for (int i = 0; i < 200 && trace_level_o != '0; i++) cycles(1);
    check("drain_level", 32'(trace_level_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(trace_valid_o), 32'd0);
    check({tag, "_data"},  trace_data_o,       32'd0);
    check({tag, "_last"},  32'(trace_last_o),  32'd0);
    check({tag, "_drops"}, 32'(trace_drops_o), 32'd0);
    check({tag, "_level"}, 32'(trace_level_o), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check_all_zero("rst");
    #11 rst_ni = 1'b1;
    cycles(1);

    // 1: single retire, ready high, fixed latency and beat contents
    trace_en_i    = 1'b1;
    trace_ready_i = 1'b1;
    {rvfi_trap, rvfi_halt, rvfi_intr} = 3'b000;
    rvfi_mode     = 2'd3;
    rvfi_rd_addr  = 5'd1;
    rvfi_rd_wdata = 32'h5;
    rvfi_pc_rdata = 32'h100;
    rvfi_insn     = 32'h00500093;
    rvfi_valid    = 1'b1;
    cycles(1);
    rvfi_valid = 1'b0;
    check("t1_b0_valid", 32'(trace_valid_o), 32'd1);
    check("t1_b0", trace_data_o, 32'hA1840000);
    check("t1_b0_last", 32'(trace_last_o), 32'd0);
    cycles(1);
    check("t1_b1", trace_data_o, 32'h00000100);
    cycles(1);
    check("t1_b2", trace_data_o, 32'h00500093);
    cycles(1);
    check("t1_b3", trace_data_o, 32'h00000005);
    check("t1_b3_last", 32'(trace_last_o), 32'd1);
    cycles(1);
    check("t1_idle", 32'(trace_valid_o), 32'd0);

    // 2: overflow with ready low, drop count reported by next accepted record
    trace_ready_i = 1'b0;
    repeat (10) retire_rand();
    check("t2_level", 32'(trace_level_o), 32'd8);
    check("t2_drops", 32'(trace_drops_o), 32'd2);
    trace_ready_i = 1'b1;
    cycles(4);
    check("t2_level_after_pop", 32'(trace_level_o), 32'd7);
    retire_rand();
    check("t2_drops_cleared", 32'(trace_drops_o), 32'd0);
    drain();

    // 3: ready toggling mid-record
    trace_ready_i = 1'b0;
    retire_rand();
    for (int i = 0; i < 8; i++) begin
      trace_ready_i = (i % 2 == 0);
      cycles(1);
    end
    check("t3_level", 32'(trace_level_o), 32'd0);
    check("t3_valid", 32'(trace_valid_o), 32'd0);

    // 4: full FIFO, final-beat pop coincides with a retire -> dropped
    trace_ready_i = 1'b0;
    repeat (8) retire_rand();
    check("t4_full", 32'(trace_level_o), 32'd8);
    trace_ready_i = 1'b1;
    cycles(3);
    check("t4_beat3_last", 32'(trace_last_o), 32'd1);
    retire_rand();
    trace_ready_i = 1'b0;
    check("t4_level", 32'(trace_level_o), 32'd7);
    check("t4_drops", 32'(trace_drops_o), 32'd1);
    drain();
    retire_rand();
    drain();
    check("t4_drops_clear", 32'(trace_drops_o), 32'd0);

    // 5: capture disabled, then reset mid-record
    trace_en_i = 1'b0;
    repeat (3) retire_rand();
    check("t5_level", 32'(trace_level_o), 32'd0);
    check("t5_drops", 32'(trace_drops_o), 32'd0);
    trace_en_i    = 1'b1;
    trace_ready_i = 1'b1;
    retire_rand();
    cycles(2);
    check("t5_beat2_valid", 32'(trace_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("t5_rst");
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cycles(1);
    check("t5_post_level", 32'(trace_level_o), 32'd0);
    check("t5_post_valid", 32'(trace_valid_o), 32'd0);

    // 6: drop counter saturation
    trace_ready_i = 1'b0;
    set_rand_fields();
    rvfi_valid = 1'b1;
    cycles(8 + 32'h10005);
    rvfi_valid = 1'b0;
    check("t6_level", 32'(trace_level_o), 32'd8);
    check("t6_drops_sat", 32'(trace_drops_o), 32'h0000FFFF);
    trace_ready_i = 1'b1;
    cycles(4);
    check("t6_level_after_pop", 32'(trace_level_o), 32'd7);
    retire_rand();
    check("t6_drops_cleared", 32'(trace_drops_o), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
